// File: rtl/conv2d_pkg.sv
// Shared constants, FSM encoding and beat arithmetic for the conv2d write-back path.
package conv2d_pkg;

  localparam int PXL_W        = 32;
  localparam int BEAT_W       = 128;
  localparam int PXL_PER_BEAT = BEAT_W / PXL_W;
  localparam int LEN_W        = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ISSUE,
    ST_PUSH,
    ST_WAIT,
    ST_FINISH
  } wmem_state_e;

  // ceil(pixels / PXL_PER_BEAT); one spare bit keeps the +3 from wrapping
  function automatic logic [LEN_W-1:0] beats_for(input logic [LEN_W-1:0] pixels);
    logic [LEN_W:0] sum;
    sum = {1'b0, pixels} + (LEN_W+1)'(PXL_PER_BEAT - 1);
    return LEN_W'(sum >> $clog2(PXL_PER_BEAT));
  endfunction

endpackage

// File: rtl/conv2d_wmem_pack.sv
// Packs 32-bit pixels into DW-bit beats, lane 0 in the LSBs; a flagged last pixel
// flushes a partial beat with the unused upper lanes zero.
module conv2d_wmem_pack
  import conv2d_pkg::*;
#(
  parameter int DW = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [PXL_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_vld,
  output logic [DW-1:0]    out_beat
);

  localparam int LANES  = DW / PXL_W;
  localparam int LANE_W = $clog2(LANES);

  logic [LANE_W-1:0] lane_p0;
  logic [DW-1:0]     acc_p0;
  logic [DW-1:0]     beat_nxt;
  logic              emit;
  logic              vld_p1;
  logic [DW-1:0]     beat_p1;

  always_comb begin
    beat_nxt = acc_p0;
    beat_nxt[int'(lane_p0) * PXL_W +: PXL_W] = in_data;
    emit = in_vld & ((lane_p0 == LANE_W'(LANES - 1)) | in_last);
  end

  // p0: lane accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_p0 <= '0;
      vld_p1  <= 1'b0;
    end else if (clr) begin
      lane_p0 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= emit;
      if (in_vld) lane_p0 <= emit ? '0 : lane_p0 + 1'b1;
    end
  end

  // p1: completed beat; accumulator restarts at zero so a flushed beat is zero-padded
  always_ff @(posedge clk) begin
    if (clr) begin
      acc_p0 <= '0;
    end else if (in_vld) begin
      acc_p0 <= emit ? '0 : beat_nxt;
    end
    if (emit) beat_p1 <= beat_nxt;
  end

  assign out_vld  = vld_p1;
  assign out_beat = beat_p1;

endmodule

// File: rtl/conv2d_wmem.sv
// conv2d write-back front-end: packs output pixels into beats, buffers them in a
// show-ahead FIFO and streams them to the write master in bounded bursts.
module conv2d_wmem
  import conv2d_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 128,
  parameter int BURST_WORDS = 32,
  parameter int FIFO_DEPTH  = 64
) (
  input  logic             clk,
  input  logic             rst,
  output logic             wmst_ctrl_fixed_location,
  output logic [AW-1:0]    wmst_ctrl_write_base,
  output logic [AW-1:0]    wmst_ctrl_write_length,
  output logic             wmst_ctrl_go,
  input  logic             wmst_ctrl_done,
  output logic             wmst_user_write_buffer,
  output logic [DW-1:0]    wmst_user_buffer_data,
  input  logic             wmst_user_buffer_full,
  input  logic             param_ena,
  input  logic [AW-1:0]    param_zaddr,
  input  logic [LEN_W-1:0] param_length_out,
  input  logic             pxl_ena_z,
  input  logic [PXL_W-1:0] pxl_z,
  output logic             pxl_ready_z,
  output logic             busy,
  output logic             done_z
);

  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int BYTE_SH = $clog2(DW / 8);

  wmem_state_e state, state_n;

  logic             ena_q1, ena_q2, done_q1, done_q2;
  logic             start, done_rise;
  logic [AW-1:0]    base_r;
  logic [LEN_W-1:0] len_r, rem_beats, pxl_cnt, pushed, chunk;
  logic             accept, last_pxl, all_in;
  logic             pack_vld;
  logic [DW-1:0]    pack_beat;
  logic [DW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr, fifo_used;
  logic             fifo_empty, fifo_rd;

  assign start     = ena_q1 & ~ena_q2;
  assign done_rise = done_q1 & ~done_q2;
  assign chunk     = (rem_beats > LEN_W'(BURST_WORDS)) ? LEN_W'(BURST_WORDS) : rem_beats;

  assign fifo_used  = wr_ptr - rd_ptr;
  assign fifo_empty = (fifo_used == '0);

  // Two slots of headroom cover the beat in the packer output register and the
  // pixel accepted while that beat is still on its way into the FIFO.
  assign busy        = (state != ST_IDLE);
  assign pxl_ready_z = busy & (pxl_cnt < len_r) & (fifo_used < (PW+1)'(FIFO_DEPTH - 2));
  assign accept      = pxl_ena_z & pxl_ready_z;
  assign last_pxl    = (pxl_cnt == len_r - 1'b1);
  assign all_in      = (pxl_cnt == len_r) & ~pack_vld;

  conv2d_wmem_pack #(.DW(DW)) u_pack (
    .clk      (clk),
    .rst      (rst),
    .clr      (start & (state == ST_IDLE)),
    .in_vld   (accept),
    .in_data  (pxl_z),
    .in_last  (last_pxl),
    .out_vld  (pack_vld),
    .out_beat (pack_beat)
  );

  always_comb begin
    state_n      = state;
    wmst_ctrl_go = 1'b0;
    fifo_rd      = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_n = ST_ARM;
      ST_ARM: begin
        if (rem_beats == '0)                                state_n = ST_FINISH;
        else if ((LEN_W'(fifo_used) >= chunk) || all_in)    state_n = ST_ISSUE;
      end
      ST_ISSUE: begin
        wmst_ctrl_go = 1'b1;
        state_n      = ST_PUSH;
      end
      ST_PUSH: begin
        fifo_rd = ~fifo_empty & ~wmst_user_buffer_full & (pushed < chunk);
        if (fifo_rd && (pushed == chunk - 1'b1)) state_n = ST_WAIT;
      end
      ST_WAIT:   if (done_rise) state_n = ST_ARM;
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ena_q1    <= 1'b0;
      ena_q2    <= 1'b0;
      done_q1   <= 1'b0;
      done_q2   <= 1'b0;
      base_r    <= '0;
      len_r     <= '0;
      rem_beats <= '0;
      pxl_cnt   <= '0;
      pushed    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state   <= state_n;
      ena_q1  <= param_ena;
      ena_q2  <= ena_q1;
      done_q1 <= wmst_ctrl_done;
      done_q2 <= done_q1;
      if (state == ST_IDLE && start) begin
        base_r    <= param_zaddr;
        len_r     <= param_length_out;
        rem_beats <= beats_for(param_length_out);
        pxl_cnt   <= '0;
      end else if (accept) begin
        pxl_cnt <= pxl_cnt + 1'b1;
      end
      if (state == ST_ISSUE)  pushed <= '0;
      else if (fifo_rd)       pushed <= pushed + 1'b1;
      // chunk accounting only advances once the master reports completion
      if (state == ST_WAIT && done_rise) begin
        base_r    <= base_r + (AW'(chunk) << BYTE_SH);
        rem_beats <= rem_beats - chunk;
      end
      if (pack_vld) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pack_vld) fifo_mem[wr_ptr[PW-1:0]] <= pack_beat;
  end

  assign wmst_ctrl_fixed_location = 1'b0;
  assign wmst_ctrl_write_base     = base_r;
  assign wmst_ctrl_write_length   = AW'(chunk) << BYTE_SH;
  assign wmst_user_write_buffer   = fifo_rd;
  assign wmst_user_buffer_data    = fifo_empty ? '0 : fifo_mem[rd_ptr[PW-1:0]];
  assign done_z                   = (state == ST_FINISH);

endmodule

// File: tb/tb_conv2d_wmem.sv
// Directed bench for conv2d_wmem with a small write-master model.
module tb_conv2d_wmem;

  logic         clk = 1'b0;
  logic         rst;
  logic         wmst_ctrl_fixed_location;
  logic [31:0]  wmst_ctrl_write_base, wmst_ctrl_write_length;
  logic         wmst_ctrl_go;
  logic         wmst_ctrl_done;
  logic         wmst_user_write_buffer;
  logic [127:0] wmst_user_buffer_data;
  logic         wmst_user_buffer_full;
  logic         param_ena;
  logic [31:0]  param_zaddr;
  logic [17:0]  param_length_out;
  logic         pxl_ena_z;
  logic [31:0]  pxl_z;
  logic         pxl_ready_z, busy, done_z;

  conv2d_wmem dut (
    .clk                      (clk),
    .rst                      (rst),
    .wmst_ctrl_fixed_location (wmst_ctrl_fixed_location),
    .wmst_ctrl_write_base     (wmst_ctrl_write_base),
    .wmst_ctrl_write_length   (wmst_ctrl_write_length),
    .wmst_ctrl_go             (wmst_ctrl_go),
    .wmst_ctrl_done           (wmst_ctrl_done),
    .wmst_user_write_buffer   (wmst_user_write_buffer),
    .wmst_user_buffer_data    (wmst_user_buffer_data),
    .wmst_user_buffer_full    (wmst_user_buffer_full),
    .param_ena                (param_ena),
    .param_zaddr              (param_zaddr),
    .param_length_out         (param_length_out),
    .pxl_ena_z                (pxl_ena_z),
    .pxl_z                    (pxl_z),
    .pxl_ready_z              (pxl_ready_z),
    .busy                     (busy),
    .done_z                   (done_z)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_start = 0;

  logic [127:0] beat_q[$];
  logic [31:0]  go_base_q[$], go_len_q[$];
  int           go_cyc_q[$], done_hi_q[$];
  int acc_cnt = 0, drop_cnt = 0, viol = 0, done_cnt = 0, done_cyc = 0;
  int m_exp = 0, m_got = 0, m_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write-master model and observation, sampled on the falling edge
  initial begin
    wmst_ctrl_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_exp = 0; m_got = 0; m_cnt = 0;
        wmst_ctrl_done = 1'b0;
      end else begin
        if (wmst_ctrl_go) begin
          go_base_q.push_back(wmst_ctrl_write_base);
          go_len_q.push_back(wmst_ctrl_write_length);
          go_cyc_q.push_back(cyc);
          m_exp = int'(wmst_ctrl_write_length) / 16;
          m_got = 0;
        end
        if (wmst_user_write_buffer) begin
          beat_q.push_back(wmst_user_buffer_data);
          m_got++;
          if (wmst_user_buffer_full) viol++;
        end
        if (pxl_ena_z && pxl_ready_z)  acc_cnt++;
        if (pxl_ena_z && !pxl_ready_z) drop_cnt++;
        if (done_z) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (m_exp != 0 && m_got == m_exp) begin
          m_exp = 0;
          m_cnt = 1;
        end else if (m_cnt > 0) begin
          m_cnt++;
          if (m_cnt == 4) begin
            wmst_ctrl_done = 1'b1;
            done_hi_q.push_back(cyc);
          end
          if (m_cnt == 6) begin
            wmst_ctrl_done = 1'b0;
            m_cnt = 0;
          end
        end
      end
    end
  end

  task automatic clear_q();
    beat_q.delete(); go_base_q.delete(); go_len_q.delete();
    go_cyc_q.delete(); done_hi_q.delete();
    acc_cnt = 0; done_cnt = 0; done_cyc = 0;
  endtask

  task automatic do_start(input int len, input logic [31:0] addr);
    @(posedge clk); #1;
    param_length_out = 18'(len);
    param_zaddr      = addr;
    param_ena        = 1'b1;
    t_start          = cyc;
    repeat (3) @(posedge clk);
    #1 param_ena = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int first);
    int i = 0;
    int cycles = 0;
    while (i < n && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
      if (pxl_ready_z) begin
        pxl_ena_z = 1'b1;
        pxl_z     = 32'(first + i);
        i++;
      end else begin
        pxl_ena_z = 1'b0;
      end
    end
    @(posedge clk); #1;
    pxl_ena_z = 1'b0;
    chk("pixel_feed", 128'(i), 128'(n));
  endtask

  task automatic wait_done(input string tag);
    int cycles = 0;
    while (done_cnt == 0 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_done_once"}, 128'(done_cnt), 128'd1);
  endtask

  task automatic check_beats(input string tag, input int n);
    int nb;
    logic [127:0] exp;
    nb = (n + 3) / 4;
    chk({tag, "_nbeats"}, 128'(beat_q.size()), 128'(nb));
    for (int j = 0; j < nb && j < beat_q.size(); j++) begin
      exp = '0;
      for (int k = 0; k < 4; k++)
        if (4 * j + k < n) exp[32 * k +: 32] = 32'(4 * j + k + 1);
      chk($sformatf("%s_beat%0d", tag, j), beat_q[j], exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    param_ena = 1'b0; param_zaddr = '0; param_length_out = '0;
    pxl_ena_z = 1'b0; pxl_z = '0; wmst_user_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_busy",   128'(busy), 128'd0);
    chk("rst_done_z", 128'(done_z), 128'd0);
    chk("rst_ready",  128'(pxl_ready_z), 128'd0);
    chk("rst_go",     128'(wmst_ctrl_go), 128'd0);
    chk("rst_wbuf",   128'(wmst_user_write_buffer), 128'd0);
    chk("rst_data",   wmst_user_buffer_data, 128'd0);
    chk("rst_base",   128'(wmst_ctrl_write_base), 128'd0);
    chk("rst_len",    128'(wmst_ctrl_write_length), 128'd0);
    chk("rst_fixed",  128'(wmst_ctrl_fixed_location), 128'd0);

    // 8 pixels -> two full beats in one burst
    clear_q();
    do_start(8, 32'h1000);
    send_pixels(8, 1);
    wait_done("t1");
    chk("t1_go_count", 128'(go_base_q.size()), 128'd1);
    if (go_base_q.size() >= 1) begin
      chk("t1_base", 128'(go_base_q[0]), 128'h1000);
      chk("t1_len",  128'(go_len_q[0]), 128'd32);
    end
    check_beats("t1", 8);
    chk("t1_idle", 128'(busy), 128'd0);

    // 6 pixels -> zero-padded final beat
    clear_q();
    do_start(6, 32'h1000);
    send_pixels(6, 1);
    wait_done("t2");
    chk("t2_go_count", 128'(go_base_q.size()), 128'd1);
    if (go_len_q.size() >= 1) chk("t2_len", 128'(go_len_q[0]), 128'd32);
    check_beats("t2", 6);

    // 200 pixels -> 32 + 18 beats, second go only after the done edge
    clear_q();
    do_start(200, 32'h1000);
    send_pixels(200, 1);
    wait_done("t3");
    chk("t3_go_count", 128'(go_base_q.size()), 128'd2);
    if (go_base_q.size() >= 2 && done_hi_q.size() >= 1) begin
      chk("t3_base0", 128'(go_base_q[0]), 128'h1000);
      chk("t3_len0",  128'(go_len_q[0]), 128'd512);
      chk("t3_base1", 128'(go_base_q[1]), 128'h1200);
      chk("t3_len1",  128'(go_len_q[1]), 128'd288);
      chk("t3_go1_after_done", 128'(go_cyc_q[1] >= done_hi_q[0] + 3), 128'd1);
    end
    check_beats("t3", 200);

    // master buffer full: FIFO fills to 62 beats, input stalls, then drains in order
    clear_q();
    wmst_user_buffer_full = 1'b1;
    do_start(280, 32'h4000);
    fork
      send_pixels(280, 1);
      begin
        repeat (400) @(negedge clk);
        chk("t4_stall_accepted", 128'(acc_cnt), 128'd249);
        chk("t4_no_push_while_full", 128'(beat_q.size()), 128'd0);
        chk("t4_ready_low", 128'(pxl_ready_z), 128'd0);
        chk("t4_one_go", 128'(go_base_q.size()), 128'd1);
        @(posedge clk); #1 wmst_user_buffer_full = 1'b0;
      end
    join
    wait_done("t4");
    chk("t4_go_count", 128'(go_base_q.size()), 128'd3);
    if (go_len_q.size() >= 3) begin
      chk("t4_base2", 128'(go_base_q[2]), 128'h4400);
      chk("t4_len2",  128'(go_len_q[2]), 128'd96);
    end
    check_beats("t4", 280);

    // empty plane
    clear_q();
    do_start(0, 32'h1000);
    wait_done("t5");
    chk("t5_done_latency", 128'(done_cyc - t_start), 128'd3);
    chk("t5_no_go", 128'(go_base_q.size()), 128'd0);

    // reset in the middle of a stalled burst, then a clean single-beat plane
    clear_q();
    wmst_user_buffer_full = 1'b1;
    do_start(140, 32'h2000);
    send_pixels(140, 1001);
    repeat (10) @(negedge clk);
    chk("t6_go_before_rst", 128'(go_base_q.size()), 128'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy",  128'(busy), 128'd0);
    chk("t6_rst_wbuf",  128'(wmst_user_write_buffer), 128'd0);
    chk("t6_rst_data",  wmst_user_buffer_data, 128'd0);
    chk("t6_rst_ready", 128'(pxl_ready_z), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wmst_user_buffer_full = 1'b0;
    clear_q();
    do_start(4, 32'h3000);
    send_pixels(4, 1);
    wait_done("t6");
    chk("t6_go_count", 128'(go_base_q.size()), 128'd1);
    if (go_base_q.size() >= 1) begin
      chk("t6_base", 128'(go_base_q[0]), 128'h3000);
      chk("t6_len",  128'(go_len_q[0]), 128'd16);
    end
    check_beats("t6", 4);

    chk("no_dropped_pixels", 128'(drop_cnt), 128'd0);
    chk("no_push_while_full", 128'(viol), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
